// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decode controller.
//
// Keeps the fetch PC, issues one request at a time to instruction memory over a
// variable-latency req/ack port, buffers returned words in a DEPTH-entry
// prefetch queue and presents one instruction per cycle to the decoder.
// Decoder controls (Br/Jmp/JAL/stall) redirect or hold the stream; wrong-path
// instructions are squashed combinationally in the redirect cycle.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   RST        in   asynchronous active-high reset
//   imem_req   out  request valid this cycle
//   imem_addr  out  request address (current fetch PC)
//   imem_ack   in   response valid (one request outstanding at most)
//   imem_rdata in   instruction word, valid with imem_ack
//   Br/Jmp/JAL in   decoder redirect controls (Jmp/JAL take priority over Br)
//   stall      in   decoder stall, holds issue
//   disp       in   signed branch displacement
//   jtarget    in   register target for Jmp/JAL
//   Q          out  instruction issued this cycle, 16'h0000 when none
//   q_valid    out  Q carries a real instruction
//   pc         out  link value: address of instruction held by decoder + 1
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               RST,
    output logic               imem_req,
    output logic [15:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    input  logic               Br,
    input  logic               Jmp,
    input  logic               JAL,
    input  logic               stall,
    input  logic signed [7:0]  disp,
    input  logic [15:0]        jtarget,
    output logic [15:0]        Q,
    output logic               q_valid,
    output logic [15:0]        pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);

    // Branch target: base plus sign-extended displacement, modulo 2^16.
    function automatic logic [15:0] branch_target(input logic [15:0] base,
                                                  input logic signed [7:0] d);
        logic signed [15:0] d_ext;
        d_ext = {{8{d[7]}}, d};
        return base + $unsigned(d_ext);
    endfunction

    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   req_addr_q, req_addr_d;
    logic [15:0]   dec_addr_q, dec_addr_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          outstanding_q, outstanding_d;
    logic          drop_q, drop_d;

    logic [15:0]   qaddr_mem  [DEPTH];
    logic [15:0]   qinstr_mem [DEPTH];

    logic          redirect;
    logic          ack_v;
    logic          push;
    logic          issue;
    logic          req;
    logic [CW:0]   occ_after;
    logic [15:0]   target;

    assign redirect = Br | Jmp | JAL;
    assign target   = (Jmp | JAL) ? jtarget : branch_target(dec_addr_q, disp);

    // An ack only counts while a request is outstanding, so a late ack after
    // reset release is ignored.
    assign ack_v = imem_ack & outstanding_q;
    assign push  = ack_v & ~drop_q & ~redirect;
    assign issue = (count_q != '0) & ~stall & ~redirect;

    // Occupancy after this cycle's pop/push decides whether there is room for
    // the word a new request would bring back.
    assign occ_after = {1'b0, count_q} + {{CW{1'b0}}, push} - {{CW{1'b0}}, issue};
    assign req       = ~redirect & ~RST & (~outstanding_q | ack_v) & (occ_after < DEPTH_EXT);

    assign imem_req  = req;
    assign imem_addr = fetch_pc_q;
    assign Q         = issue ? qinstr_mem[head_q] : 16'h0000;
    assign q_valid   = issue;
    assign pc        = dec_addr_q + 16'd1;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_addr_d    = req_addr_q;
        dec_addr_d    = dec_addr_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        if (issue) begin
            dec_addr_d = qaddr_mem[head_q];
        end

        if (redirect) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            fetch_pc_d    = target;
            // A request still in flight must have its response thrown away.
            drop_d        = outstanding_q & ~imem_ack;
            outstanding_d = outstanding_q & ~imem_ack;
        end else begin
            if (ack_v && drop_q) begin
                drop_d = 1'b0;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (issue) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, issue};
            if (req) begin
                outstanding_d = 1'b1;
                req_addr_d    = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 16'd1;
            end else if (ack_v) begin
                outstanding_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            fetch_pc_q    <= 16'h0000;
            req_addr_q    <= 16'h0000;
            dec_addr_q    <= 16'hFFFF;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= req_addr_d;
            dec_addr_q    <= dec_addr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Queue storage carries data only; validity is tracked by count/head/tail.
    always_ff @(posedge clk) begin
        if (push) begin
            qaddr_mem[tail_q]  <= req_addr_q;
            qinstr_mem[tail_q] <= imem_rdata;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode controller. Maintains the fetch PC and issues requests to instruction memory over a variable-latency request/acknowledge port. Buffers returned words in a small prefetch queue and presents one instruction per cycle on `Q` with its link value on `pc`. Applies the decoder's `Br`/`Jmp`/`JAL`/`stall` controls, squashing wrong-path instructions.

## Interface
- `DEPTH`, 2: prefetch queue entries (power of 2, ≥2); each entry holds {addr[15:0], instr[15:0]}.
- `clk` in 1: single clock, all state on rising edge.
- `RST` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `imem_req` out 1: request valid this cycle (combinational from state and inputs).
- `imem_addr` out 16: request address, equal to `fetch_pc`.
- `imem_ack` in 1: response valid; at most one request outstanding; ack ≥1 cycle after req.
- `imem_rdata` in 16: instruction word, valid with `imem_ack`.
- `Br`, `Jmp`, `JAL`, `stall` in 1 each: decoder controls, combinational from decoder's latched instruction.
- `disp` in 8: branch displacement, two's complement.
- `jtarget` in 16: register value for Jcond/JAL target.
- `Q` out 16: instruction issued to decoder this cycle; 16'h0000 (Wait/NOP) when none.
- `q_valid` out 1: `Q` carries a real instruction.
- `pc` out 16: link value = `dec_addr` + 1 (address of instruction held by decoder, plus 1).

## Operation
- State: `fetch_pc`[15:0], queue (head/tail pointers, count 0..DEPTH), `outstanding`, `drop`, `dec_addr`[15:0].
- Reset values: `fetch_pc`=0, queue empty, `outstanding`=0, `drop`=0, `dec_addr`=16'hFFFF. Outputs during and after reset: `Q`=0, `q_valid`=0, `pc`=0, `imem_req`=0 while RST high.
- `redirect` = `Br` | `Jmp` | `JAL`.
- Target: if `Jmp`|`JAL` → `jtarget`. Otherwise (`Br`) → `dec_addr` + sext(`disp`). Jmp/JAL take priority over Br. Arithmetic is mod 2^16.
- Issue: `issue` = queue non-empty & ~`stall` & ~`redirect`. When issue, `Q` = head instr, `q_valid`=1, pop head, `dec_addr` ← head addr. Otherwise `Q`=0, `q_valid`=0, `dec_addr` held. `Q` is combinational, so a redirect squashes the same cycle.
- Push: `imem_ack` & ~`drop` & ~`redirect` → write {`imem_addr` of that request, `imem_rdata`} at tail. The captured request address is kept in a register.
- Request: `imem_req` = ~`redirect` & ~RST & (~`outstanding` | `imem_ack`) & (count − issue + push < DEPTH). On req: `outstanding` ← 1, `fetch_pc` ← `fetch_pc` + 1 (16'hFFFF wraps to 0). On ack with no new req: `outstanding` ← 0.
- Redirect, on the edge ending the redirect cycle:
  - Flush the queue (count=0).
  - `fetch_pc` ← target.
  - `drop` ← `outstanding` & ~`imem_ack`.
  - A response acked in the redirect cycle is discarded.
  - `dec_addr` unchanged.
- `drop`: the next `imem_ack` is discarded and clears `drop`. A new req is allowed in that same ack cycle.
- `stall` with no redirect: queue, `fetch_pc`, and `dec_addr` hold except for push/req, which continue while space exists.
- Async reset mid-transaction: all state returns to reset values immediately. A late ack after reset release while `outstanding`=0 is ignored.

## Timing
- Cycle 0 = first cycle with RST low: `imem_req`=1, `imem_addr`=0.
- Single-cycle memory (ack in cycle 1): instr@0 on `Q` in cycle 2. After that, one instruction per cycle, since queue occupancy settles at 1.
- Redirect penalty with single-cycle memory:
  - Redirect in cycle n.
  - Req at target in n+1.
  - Target on `Q` in n+3.
  - `Q`=0 in n, n+1, n+2.
- Throughput with k-cycle ack latency: one instruction per k cycles.
- `pc` changes only on the edge following an issue cycle.

## Test plan
- Reset then sequential stream, single-cycle memory returning rdata=addr^16'hA500: `Q`=16'hA500, 16'hA501, 16'hA502… on cycles 2, 3, 4. `pc`=1, 2, 3 one cycle after each.
- Bcond: decoder holds instr@0x0010, `Br`=1, `disp`=8'hFC. Required: `Q`=0 that cycle, `imem_addr`=0x000C next cycle, instr@0x000C on `Q` 3 cycles after redirect, and instr@0x0011 is never issued.
- JAL at 0x0020 with `jtarget`=0x0100: `pc`=0x0021 while asserted. Next fetch is 0x0100.
- Slow memory (ack 3 cycles after req), Jmp to 0x0040 while a req@0x0005 is outstanding: the ack for 0x0005 is dropped, the next req is 0x0040, and no word from 0x0005 appears on `Q`.
- `stall`=1 for 3 cycles with queue full: `Q`=0 and `imem_req`=0 for those cycles. On release, issue resumes with the held head instruction.
- Wrap-around: `Jmp` to 0xFFFF yields fetches 0xFFFF, 0x0000. Assert RST mid-stream: `Q`=0 and `pc`=0 immediately, and fetch restarts at 0 after release.
